// File: rtl/dpb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpb_pkg
// Description : Shared types for the DPB -> DDR3 write scheduler: the queued
//               write descriptor and the scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dpb_pkg;

  localparam int RANK_NUM = 16;

  // One filled DPB rank waiting to be written to DDR3
  typedef struct packed {
    logic [3:0] rank;
    logic [6:0] cnt128;
    logic [5:0] bytecnt;
    logic [7:0] udp_rank;
    logic       last;
  } dpb_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DOWN = 2'd2,
    ST_RETIRE    = 2'd3
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/dpb_desc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dpb_desc_fifo
// Description : Synchronous descriptor FIFO with first-word fall-through head.
//               A push and a pop in the same cycle are legal even when full:
//               the freed head slot is the one being written.
// Revision    : 1.0 - initial release
// ============================================================================
module dpb_desc_fifo
  import dpb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  dpb_desc_t data_i,
  input  logic      pop_i,
  output dpb_desc_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  dpb_desc_t   mem_q [DEPTH];

  // Storage array, written at the tail
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  // Pointer advance; the caller only pushes/pops when legal
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/dpb_ddr3_wr_sched.sv
`default_nettype none
// ============================================================================
// Module      : dpb_ddr3_wr_sched
// Description : Queues filled DPB ranks and issues them in order to the DDR3
//               write master with a held req / pulsed down handshake.
//               Computes slot addresses, ping-pongs frame buffers, tracks
//               busy ranks and flags overflow and handshake timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module dpb_ddr3_wr_sched
  import dpb_pkg::*;
#(
  parameter int                DESC_DEPTH   = 8,
  parameter int                ADDR_W       = 28,
  parameter logic [ADDR_W-1:0] FRAME_BASE   = '0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'('h40000),
  parameter logic [ADDR_W-1:0] SLOT_STRIDE  = ADDR_W'('h800),
  parameter int                TIMEOUT_CYC  = 4096
) (
  input  logic                i_pclk,
  input  logic                i_rst_n,
  input  logic                i_buf_req,
  input  logic [3:0]          i_buf_rank,
  input  logic [6:0]          i_buf_128cnt,
  input  logic [5:0]          i_buf_bytecnt,
  input  logic [7:0]          i_udp_rank,
  input  logic                i_frame_down,
  output logic [15:0]         o_rank_busy,
  output logic                o_queue_full,
  output logic                o_ddr3_wr_req,
  output logic [3:0]          o_ddr3_wr_rank,
  output logic [6:0]          o_ddr3_wr_128cnt,
  output logic [5:0]          o_ddr3_wr_bytecnt,
  output logic [ADDR_W-1:0]   o_ddr3_wr_addr,
  output logic                o_ddr3_wr_last,
  input  logic                i_ddr3_wr_down,
  output logic                o_frame_done,
  output logic                o_frame_idx,
  output logic [7:0]          o_frame_pkt_cnt,
  output logic                o_error,
  output logic [7:0]          o_ovf_cnt
);

  localparam int              TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  sched_state_e         state_q;
  logic [TMO_W-1:0]     tmo_q;
  logic                 req_q;
  logic [3:0]           wr_rank_q;
  logic [6:0]           wr_cnt_q;
  logic [5:0]           wr_bytes_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic                 wr_last_q;
  logic                 frame_sel_q;
  logic [7:0]           pkt_cnt_q;
  logic                 frame_done_q;
  logic                 frame_idx_q;
  logic [7:0]           frame_pkt_q;
  logic [RANK_NUM-1:0]  rank_busy_q, rank_busy_d;
  logic [7:0]           ovf_cnt_q, ovf_cnt_d;
  logic                 error_q, error_d;

  dpb_desc_t            push_desc;
  dpb_desc_t            head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push_acc;
  logic                 ovf_evt;
  logic                 tmo_hit;
  logic                 tmo_evt;
  logic [ADDR_W-1:0]    addr_d;

  // A retire frees a slot in the same cycle, so a push into a full queue is
  // still accepted then
  assign pop      = (state_q == ST_RETIRE);
  assign push_acc = i_buf_req && (!fifo_full || pop);
  assign ovf_evt  = i_buf_req && fifo_full && !pop;
  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign tmo_evt  = (state_q == ST_WAIT_DOWN) && !i_ddr3_wr_down && tmo_hit;
  assign addr_d   = FRAME_BASE + (frame_sel_q ? FRAME_STRIDE : '0) +
                    (ADDR_W'(head.udp_rank) * SLOT_STRIDE);

  // Pack the writer's inputs into a descriptor
  always_comb begin
    push_desc = '{rank:     i_buf_rank,
                  cnt128:   i_buf_128cnt,
                  bytecnt:  i_buf_bytecnt,
                  udp_rank: i_udp_rank,
                  last:     i_frame_down};
  end

  dpb_desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_fifo (
    .clk_i   (i_pclk),
    .rst_ni  (i_rst_n),
    .push_i  (push_acc),
    .data_i  (push_desc),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Busy mask, overflow counter and sticky error: retire clear before push set
  always_comb begin
    rank_busy_d = rank_busy_q;
    if (pop)      rank_busy_d[wr_rank_q]  = 1'b0;
    if (push_acc) rank_busy_d[i_buf_rank] = 1'b1;
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_evt && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    error_d = error_q | ovf_evt | tmo_evt;
  end

  // Bookkeeping registers
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rank_busy_q <= '0;
      ovf_cnt_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      rank_busy_q <= rank_busy_d;
      ovf_cnt_q   <= ovf_cnt_d;
      error_q     <= error_d;
    end
  end

  // Scheduler FSM with registered handshake, descriptor and frame outputs
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      req_q        <= 1'b0;
      wr_rank_q    <= '0;
      wr_cnt_q     <= '0;
      wr_bytes_q   <= '0;
      wr_addr_q    <= '0;
      wr_last_q    <= 1'b0;
      frame_sel_q  <= 1'b0;
      pkt_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      frame_idx_q  <= 1'b0;
      frame_pkt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          wr_rank_q  <= head.rank;
          wr_cnt_q   <= head.cnt128;
          wr_bytes_q <= head.bytecnt;
          wr_last_q  <= head.last;
          wr_addr_q  <= addr_d;
          tmo_q      <= '0;
          req_q      <= 1'b1;
          state_q    <= ST_WAIT_DOWN;
        end
        ST_WAIT_DOWN: begin
          if (i_ddr3_wr_down || tmo_hit) begin
            req_q   <= 1'b0;
            state_q <= ST_RETIRE;
            // Frame-done is staged here so its pulse lines up with RETIRE
            if (wr_last_q) begin
              frame_done_q <= 1'b1;
              frame_idx_q  <= frame_sel_q;
              frame_pkt_q  <= pkt_cnt_q + 8'd1;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_RETIRE: begin
          if (wr_last_q) begin
            frame_sel_q <= ~frame_sel_q;
            pkt_cnt_q   <= '0;
          end else begin
            pkt_cnt_q   <= pkt_cnt_q + 8'd1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_rank_busy       = rank_busy_q;
  assign o_queue_full      = fifo_full;
  assign o_ddr3_wr_req     = req_q;
  assign o_ddr3_wr_rank    = wr_rank_q;
  assign o_ddr3_wr_128cnt  = wr_cnt_q;
  assign o_ddr3_wr_bytecnt = wr_bytes_q;
  assign o_ddr3_wr_addr    = wr_addr_q;
  assign o_ddr3_wr_last    = wr_last_q;
  assign o_frame_done      = frame_done_q;
  assign o_frame_idx       = frame_idx_q;
  assign o_frame_pkt_cnt   = frame_pkt_q;
  assign o_error           = error_q;
  assign o_ovf_cnt         = ovf_cnt_q;

endmodule
`default_nettype wire
